// File: rtl/video_mode_ctrl_if.sv
// video_mode_ctrl_if
// Groups the button/frame/auto-cycle inputs and the registered mode outputs
// of the video mode controller into one bundle.
//   bg_btn_in        : pulse, request next background mode
//   target_btn_in    : pulse, request next overlay mode
//   new_frame_in     : pulse at start of vertical blanking
//   auto_en_in       : level, enables automatic mode cycling
//   bg_out           : background select for the video mux
//   target_out       : overlay select for the video mux
//   pending_out      : a manual change is waiting for a frame boundary
//   mode_changed_out : one-cycle pulse when the visible mode changed
// The controller uses the slave modport; whoever drives the buttons uses master.
interface video_mode_ctrl_if;
   logic       bg_btn_in;
   logic       target_btn_in;
   logic       new_frame_in;
   logic       auto_en_in;
   logic [1:0] bg_out;
   logic [1:0] target_out;
   logic       pending_out;
   logic       mode_changed_out;

   modport master (
      output bg_btn_in,
      output target_btn_in,
      output new_frame_in,
      output auto_en_in,
      input  bg_out,
      input  target_out,
      input  pending_out,
      input  mode_changed_out
   );

   modport slave (
      input  bg_btn_in,
      input  target_btn_in,
      input  new_frame_in,
      input  auto_en_in,
      output bg_out,
      output target_out,
      output pending_out,
      output mode_changed_out
   );
endinterface

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl
// Selects the background and overlay modes of a video mux. Button presses
// accumulate in shadow registers and are applied atomically at the next frame
// boundary so the picture never changes mid-frame. With auto_en_in set and no
// manual request outstanding, the combined mode steps every AUTO_FRAMES frames.
// Ports:
//   clk_in   : pixel clock, the only clock
//   rst_n_in : synchronous active-low reset
//   bus      : video_mode_ctrl_if.slave (buttons, frame pulse, auto enable,
//              registered mode outputs, pending and mode-changed flags)
module video_mode_ctrl #(
   parameter int unsigned AUTO_FRAMES = 60,
   parameter bit          ALLOW_TEST  = 1'b0
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   video_mode_ctrl_if.slave   bus
);

   localparam logic [15:0] LAST_FRAME = 16'(AUTO_FRAMES - 1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  bg_next_q, bg_next_d;
   logic [1:0]  target_next_q, target_next_d;
   logic [1:0]  bg_q, bg_d;
   logic [1:0]  target_q, target_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        mode_changed_q, mode_changed_d;
   logic        btn_any_s;

   // The test-colour code 2'b11 is skipped entirely unless ALLOW_TEST is set,
   // so target can never reach it in a production build.
   function automatic logic [1:0] next_target(input logic [1:0] t);
      logic [1:0] r;
      case (t)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b10;
         2'b10:   r = ALLOW_TEST ? 2'b11 : 2'b00;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Next-state, shadow, counter and output computation.
   always_comb begin
      state_d        = state_q;
      bg_next_d      = bg_next_q;
      target_next_d  = target_next_q;
      bg_d           = bg_q;
      target_d       = target_q;
      frame_cnt_d    = frame_cnt_q;
      btn_any_s      = bus.bg_btn_in | bus.target_btn_in;

      if (bus.bg_btn_in) begin
         bg_next_d = bg_next_q + 2'd1;
      end else begin
         bg_next_d = bg_next_q;
      end

      if (bus.target_btn_in) begin
         target_next_d = next_target(target_next_q);
      end else begin
         target_next_d = target_next_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (btn_any_s) begin
               // A press always defers to the next frame, even if it
               // coincides with this frame pulse.
               state_d     = ST_PENDING;
               frame_cnt_d = 16'd0;
            end else if (!bus.auto_en_in) begin
               frame_cnt_d = 16'd0;
            end else if (bus.new_frame_in) begin
               if (frame_cnt_q == LAST_FRAME) begin
                  frame_cnt_d   = 16'd0;
                  bg_d          = bg_q + 2'd1;
                  target_d      = (bg_q == 2'b11) ? next_target(target_q) : target_q;
                  // Keep shadows in step so a later press starts from here.
                  bg_next_d     = bg_d;
                  target_next_d = target_d;
               end else begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end else begin
               frame_cnt_d = frame_cnt_q;
            end
         end
         ST_PENDING: begin
            frame_cnt_d = 16'd0;
            if (bus.new_frame_in) begin
               // Apply the shadows as they stood before this cycle's press.
               bg_d     = bg_next_q;
               target_d = target_next_q;
               state_d  = btn_any_s ? ST_PENDING : ST_IDLE;
            end else begin
               state_d = ST_PENDING;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            frame_cnt_d = 16'd0;
         end
      endcase

      mode_changed_d = ({target_d, bg_d} != {target_q, bg_q});
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q        <= ST_IDLE;
         bg_next_q      <= 2'b00;
         target_next_q  <= 2'b00;
         bg_q           <= 2'b00;
         target_q       <= 2'b00;
         frame_cnt_q    <= 16'd0;
         mode_changed_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         bg_next_q      <= bg_next_d;
         target_next_q  <= target_next_d;
         bg_q           <= bg_d;
         target_q       <= target_d;
         frame_cnt_q    <= frame_cnt_d;
         mode_changed_q <= mode_changed_d;
      end
   end

   assign bus.bg_out           = bg_q;
   assign bus.target_out       = target_q;
   assign bus.pending_out      = (state_q == ST_PENDING);
   assign bus.mode_changed_out = mode_changed_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl
// Drives two controllers (ALLOW_TEST=0 and ALLOW_TEST=1, both AUTO_FRAMES=3)
// with identical stimulus. Every cycle a behavioural model pushes the expected
// outputs of both instances to a queue; a monitor pops and compares after each
// clock edge. Scenario tasks add directed checks against hand-derived values.
module tb_video_mode_ctrl;
   localparam int AUTO = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   ae = 1'b0;

   always #5 clk = ~clk;

   video_mode_ctrl_if bus0 ();
   video_mode_ctrl_if bus1 ();

   assign bus1.bg_btn_in     = bus0.bg_btn_in;
   assign bus1.target_btn_in = bus0.target_btn_in;
   assign bus1.new_frame_in  = bus0.new_frame_in;
   assign bus1.auto_en_in    = bus0.auto_en_in;

   video_mode_ctrl #(.AUTO_FRAMES(AUTO), .ALLOW_TEST(1'b0)) dut0 (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus0.slave));
   video_mode_ctrl #(.AUTO_FRAMES(AUTO), .ALLOW_TEST(1'b1)) dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus1.slave));

   int total = 0;
   int bad   = 0;
   logic [11:0] sb_q[$];
   logic [11:0] sb_exp, sb_got;

   // Model state; index 0 = ALLOW_TEST 0, index 1 = ALLOW_TEST 1.
   int m_bg[2], m_tg[2], m_bgn[2], m_tgn[2], m_pend[2], m_cnt[2], m_mc[2];

   function automatic int tadv(input int t, input int allow);
      if (t == 0) return 1;
      if (t == 1) return 2;
      if (t == 2) return (allow != 0) ? 3 : 0;
      return 0;
   endfunction

   task automatic model_step(input int k, input bit r, input bit b, input bit t,
                             input bit nf, input bit a);
      int old_o, nbn, ntn;
      if (!r) begin
         m_bg[k] = 0; m_tg[k] = 0; m_bgn[k] = 0; m_tgn[k] = 0;
         m_pend[k] = 0; m_cnt[k] = 0; m_mc[k] = 0;
      end else begin
         old_o = m_tg[k] * 4 + m_bg[k];
         nbn = b ? (m_bgn[k] + 1) % 4 : m_bgn[k];
         ntn = t ? tadv(m_tgn[k], k) : m_tgn[k];
         if (m_pend[k] != 0) begin
            m_cnt[k] = 0;
            if (nf) begin
               m_bg[k] = m_bgn[k];
               m_tg[k] = m_tgn[k];
               m_pend[k] = (b || t) ? 1 : 0;
            end
         end else if (b || t) begin
            m_pend[k] = 1;
            m_cnt[k] = 0;
         end else if (!a) begin
            m_cnt[k] = 0;
         end else if (nf) begin
            if (m_cnt[k] == AUTO - 1) begin
               m_cnt[k] = 0;
               m_bg[k] = (m_bg[k] + 1) % 4;
               if (m_bg[k] == 0) m_tg[k] = tadv(m_tg[k], k);
               nbn = m_bg[k];
               ntn = m_tg[k];
            end else begin
               m_cnt[k] = m_cnt[k] + 1;
            end
         end
         m_bgn[k] = nbn;
         m_tgn[k] = ntn;
         m_mc[k] = ((m_tg[k] * 4 + m_bg[k]) != old_o) ? 1 : 0;
      end
   endtask

   // One clock cycle: drive at the falling edge, predict, return just after the rising edge.
   task automatic tick(input bit r, input bit b, input bit t, input bit nf);
      @(negedge clk);
      rst_n              = r;
      bus0.bg_btn_in     = b;
      bus0.target_btn_in = t;
      bus0.new_frame_in  = nf;
      bus0.auto_en_in    = ae;
      model_step(0, r, b, t, nf, ae);
      model_step(1, r, b, t, nf, ae);
      sb_q.push_back({2'(m_tg[1]), 2'(m_bg[1]), 1'(m_pend[1]), 1'(m_mc[1]),
                      2'(m_tg[0]), 2'(m_bg[0]), 1'(m_pend[0]), 1'(m_mc[0])});
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compare both instances against the model after each edge.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         sb_exp = sb_q.pop_front();
         sb_got = {bus1.target_out, bus1.bg_out, bus1.pending_out, bus1.mode_changed_out,
                   bus0.target_out, bus0.bg_out, bus0.pending_out, bus0.mode_changed_out};
         total++;
         if (sb_got !== sb_exp) begin
            bad++;
            $display("FAIL scoreboard t=%0t got=%b exp=%b", $time, sb_got, sb_exp);
         end
         total++;
         if (bus0.target_out === 2'b11) begin
            bad++;
            $display("FAIL no_test_colour got=%b exp=not 11", bus0.target_out);
         end
      end
   end

   task automatic test_reset();
      ae = 1'b0;
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if ({bus0.target_out, bus0.bg_out, bus0.pending_out, bus0.mode_changed_out} !== 6'b0) begin
         bad++;
         $display("FAIL reset_state got=%b exp=000000",
                  {bus0.target_out, bus0.bg_out, bus0.pending_out, bus0.mode_changed_out});
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus0.pending_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_discard got=%b exp=0", bus0.pending_out);
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (bus0.pending_out !== 1'b1) begin
         bad++;
         $display("FAIL first_press got=%b exp=1", bus0.pending_out);
      end
   endtask

   task automatic test_single_bg();
      int pcnt, mcnt;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      pcnt = int'(bus0.pending_out);
      mcnt = 0;
      for (int i = 1; i < 10; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         pcnt += int'(bus0.pending_out);
      end
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      mcnt += int'(bus0.mode_changed_out);
      total++;
      if (bus0.bg_out !== 2'b01) begin
         bad++;
         $display("FAIL single_bg_out got=%b exp=01", bus0.bg_out);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         mcnt += int'(bus0.mode_changed_out);
      end
      total++;
      if (pcnt != 10) begin
         bad++;
         $display("FAIL single_bg_pending_cycles got=%0d exp=10", pcnt);
      end
      total++;
      if (mcnt != 1) begin
         bad++;
         $display("FAIL single_bg_changed_pulses got=%0d exp=1", mcnt);
      end
   endtask

   task automatic test_target_wrap();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (bus0.target_out !== 2'b10) begin
         bad++;
         $display("FAIL target_wrap_no_test got=%b exp=10", bus0.target_out);
      end
      total++;
      if (bus1.target_out !== 2'b01) begin
         bad++;
         $display("FAIL target_wrap_test got=%b exp=01", bus1.target_out);
      end
   endtask

   task automatic test_coincident();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      total++;
      if ({bus0.bg_out, bus0.pending_out, bus0.mode_changed_out} !== 4'b0010) begin
         bad++;
         $display("FAIL coincident_idle got=%b exp=0010",
                  {bus0.bg_out, bus0.pending_out, bus0.mode_changed_out});
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (bus0.bg_out !== 2'b01) begin
         bad++;
         $display("FAIL coincident_next_frame got=%b exp=01", bus0.bg_out);
      end
      // Press while pending and coincident with the frame: old shadow applied, stays pending.
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      total++;
      if ({bus0.bg_out, bus0.pending_out} !== 3'b101) begin
         bad++;
         $display("FAIL coincident_pending got=%b exp=101", {bus0.bg_out, bus0.pending_out});
      end
   endtask

   task automatic test_both_buttons();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if ({bus0.target_out, bus0.bg_out} !== 4'b0101) begin
         bad++;
         $display("FAIL both_buttons got=%b exp=0101", {bus0.target_out, bus0.bg_out});
      end
   endtask

   task automatic test_net_wrap();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if ({bus0.target_out, bus0.bg_out, bus0.pending_out, bus0.mode_changed_out} !== 6'b0) begin
         bad++;
         $display("FAIL net_wrap got=%b exp=000000",
                  {bus0.target_out, bus0.bg_out, bus0.pending_out, bus0.mode_changed_out});
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus0.mode_changed_out !== 1'b0) begin
         bad++;
         $display("FAIL net_wrap_pulse got=%b exp=0", bus0.mode_changed_out);
      end
   endtask

   task automatic test_auto();
      logic [1:0] exp_bg [4];
      exp_bg = '{2'b01, 2'b10, 2'b11, 2'b00};
      ae = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 12; f++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b1);
         if (f % 3 == 2) begin
            total++;
            if (bus0.bg_out !== exp_bg[f / 3]) begin
               bad++;
               $display("FAIL auto_step%0d_bg got=%b exp=%b", f / 3, bus0.bg_out, exp_bg[f / 3]);
            end
            total++;
            if (bus0.target_out !== ((f == 11) ? 2'b01 : 2'b00)) begin
               bad++;
               $display("FAIL auto_step%0d_target got=%b exp=%b", f / 3, bus0.target_out,
                        (f == 11) ? 2'b01 : 2'b00);
            end
         end
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         tick(1'b1, 1'b0, 1'b0, 1'b0);
      end
      ae = 1'b0;
   endtask

   task automatic test_auto_disable();
      ae = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      ae = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (bus0.bg_out !== 2'b00) begin
         bad++;
         $display("FAIL auto_off_frozen got=%b exp=00", bus0.bg_out);
      end
      ae = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (bus0.bg_out !== 2'b00) begin
         bad++;
         $display("FAIL auto_counter_cleared got=%b exp=00", bus0.bg_out);
      end
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (bus0.bg_out !== 2'b01) begin
         bad++;
         $display("FAIL auto_resume got=%b exp=01", bus0.bg_out);
      end
      ae = 1'b0;
   endtask

   task automatic test_reset_pending();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if ({bus0.target_out, bus0.pending_out} !== 3'b011) begin
         bad++;
         $display("FAIL rst_pend_setup got=%b exp=011", {bus0.target_out, bus0.pending_out});
      end
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      total++;
      if ({bus0.target_out, bus0.bg_out, bus0.pending_out, bus0.mode_changed_out} !== 6'b0) begin
         bad++;
         $display("FAIL rst_pend_clear got=%b exp=000000",
                  {bus0.target_out, bus0.bg_out, bus0.pending_out, bus0.mode_changed_out});
      end
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if ({bus0.target_out, bus0.bg_out, bus0.mode_changed_out} !== 5'b0) begin
         bad++;
         $display("FAIL rst_pend_frame got=%b exp=00000",
                  {bus0.target_out, bus0.bg_out, bus0.mode_changed_out});
      end
   endtask

   task automatic test_back_to_back();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(39, 0) == 0) ae = ~ae;
         tick(($urandom_range(49, 0) != 0),
              ($urandom_range(4, 0) == 0),
              ($urandom_range(4, 0) == 0),
              ($urandom_range(3, 0) == 0));
      end
      ae = 1'b0;
   endtask

   initial begin
      bus0.bg_btn_in     = 1'b0;
      bus0.target_btn_in = 1'b0;
      bus0.new_frame_in  = 1'b0;
      bus0.auto_en_in    = 1'b0;
      test_reset();
      test_single_bg();
      test_target_wrap();
      test_coincident();
      test_both_buttons();
      test_net_wrap();
      test_auto();
      test_auto_disable();
      test_reset_pending();
      test_back_to_back();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
